// File: rtl/sp_ram_pkg.sv
// Shared types and address-decode helpers for the multi-port banked SRAM wrapper.
package sp_ram_pkg;

  typedef enum logic {
    INTLV_CONTIG = 1'b0,
    INTLV_WORD   = 1'b1
  } intlv_e;

  // Bank ids travel through the response pipe at this fixed width.
  localparam int unsigned BANK_ID_W = 8;

  // Per-port response record: what to deliver one cycle after a grant.
  typedef struct packed {
    logic                 valid;
    logic                 is_write;
    logic [BANK_ID_W-1:0] bank;
  } rsp_pipe_t;

  // Bank index of a zero-extended byte address.
  function automatic logic [31:0] bank_idx(input logic [31:0] addr,
                                           input int unsigned aw,
                                           input int unsigned woff,
                                           input int unsigned bb,
                                           input intlv_e      mode);
    logic [31:0] mask;
    mask = (32'd1 << bb) - 32'd1;
    if (bb == 0) return 32'd0;
    if (mode == INTLV_WORD) return (addr >> woff) & mask;
    return (addr >> (aw - bb)) & mask;
  endfunction

  // Word row inside the selected bank.
  function automatic logic [31:0] row_idx(input logic [31:0] addr,
                                          input int unsigned aw,
                                          input int unsigned woff,
                                          input int unsigned bb,
                                          input intlv_e      mode);
    logic [31:0] mask;
    mask = (32'd1 << (aw - woff - bb)) - 32'd1;
    if (mode == INTLV_WORD) return (addr >> (woff + bb)) & mask;
    return (addr >> woff) & mask;
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port byte-enabled SRAM bank with registered read data; contents are not reset.
module sp_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 8192,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_WORDS / (DATA_WIDTH / 8))
) (
  input  logic                      clk,
  input  logic                      en_i,
  input  logic                      we_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic [DATA_WIDTH-1:0]     rdata_o
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = NUM_WORDS / NB;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // One access per edge: byte-masked write or registered read.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < NB; i++) begin
          if (be_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/sp_ram_rr_arb.sv
// Round-robin arbiter for one bank: one-hot combinational grant, pointer advances past the winner.
module sp_ram_rr_arb #(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        ptr_d;
  logic [NUM_PORTS-1:0] gnt_c;

  // Pointer register; restarts at port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // First requester at or after the pointer wins; pointer moves only on a grant.
  always_comb begin
    int unsigned idx;
    logic        found;
    gnt_c = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (32'(ptr_q) + 32'(i)) % NUM_PORTS;
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt_c[idx] = 1'b1;
        ptr_d      = (idx == NUM_PORTS - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  assign gnt = gnt_c;

endmodule

// File: rtl/sp_ram_mp_bank_wrap.sv
// Multi-port, multi-bank SRAM wrapper: per-bank RR arbitration, 1-cycle responses, conflict counter.
module sp_ram_mp_bank_wrap
  import sp_ram_pkg::*;
#(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned INTERLEAVE = 1,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE)
) (
  input  logic                                clk,
  input  logic                                rstn_i,
  input  logic [NUM_PORTS-1:0]                req_i,
  output logic [NUM_PORTS-1:0]                gnt_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     addr_i,
  input  logic [NUM_PORTS-1:0]                we_i,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     wdata_i,
  output logic [NUM_PORTS-1:0]                rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     rdata_o,
  input  logic                                bypass_en_i,
  output logic [31:0]                         conflict_o
);

  localparam int unsigned NB   = DATA_WIDTH / 8;
  localparam int unsigned WOFF = $clog2(NB);
  localparam int unsigned BB   = $clog2(NUM_BANKS);
  localparam int unsigned BW   = (NUM_BANKS > 1) ? BB : 1;
  localparam int unsigned RW   = ADDR_WIDTH - WOFF - BB;
  localparam intlv_e      MODE = (INTERLEAVE != 0) ? INTLV_WORD : INTLV_CONTIG;

  logic [BW-1:0]         port_bank  [NUM_PORTS];
  logic [RW-1:0]         port_row   [NUM_PORTS];
  logic [NUM_PORTS-1:0]  bank_req   [NUM_BANKS];
  logic [NUM_PORTS-1:0]  bank_gnt   [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [NUM_PORTS-1:0]  gnt_c;

  rsp_pipe_t             rsp_q    [NUM_PORTS];
  rsp_pipe_t             rsp_d    [NUM_PORTS];
  logic [DATA_WIDTH-1:0] hold_q   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rsp_data [NUM_PORTS];

  logic [31:0] conflict_q;
  logic [31:0] conflict_d;
  logic [31:0] miss_cnt;
  logic [32:0] conflict_sum;

  // Split each port address into bank and row.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_bank[p] = BW'(bank_idx(32'(addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
                                  ADDR_WIDTH, WOFF, BB, MODE));
      port_row[p]  = RW'(row_idx(32'(addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
                                 ADDR_WIDTH, WOFF, BB, MODE));
    end
  end

  // Route each request to the bank it targets.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_req[b] = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        bank_req[b][p] = req_i[p] && (port_bank[p] == BW'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                  en;
    logic                  we;
    logic [NB-1:0]         be;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] wdata;

    sp_ram_rr_arb #(
      .NUM_PORTS (NUM_PORTS)
    ) u_arb (
      .clk   (clk),
      .rst_n (rstn_i),
      .req   (bank_req[b]),
      .gnt   (bank_gnt[b])
    );

    // Winner drives the bank; bypassed writes keep the bank idle.
    always_comb begin
      en    = 1'b0;
      we    = 1'b0;
      be    = '0;
      row   = '0;
      wdata = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bank_gnt[b][p]) begin
          en    = !(we_i[p] && bypass_en_i);
          we    = we_i[p];
          be    = be_i[p*NB +: NB];
          row   = port_row[p];
          wdata = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    sp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WORDS  (RAM_SIZE / NUM_BANKS),
      .ADDR_WIDTH (RW)
    ) u_ram (
      .clk     (clk),
      .en_i    (en),
      .we_i    (we),
      .be_i    (be),
      .addr_i  (row),
      .wdata_i (wdata),
      .rdata_o (bank_rdata[b])
    );
  end

  // A port is granted by whichever bank it addressed.
  always_comb begin
    gnt_c = '0;
    for (int b = 0; b < NUM_BANKS; b++) gnt_c = gnt_c | bank_gnt[b];
  end

  assign gnt_o = gnt_c;

  // Next response record and conflict count.
  always_comb begin
    miss_cnt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp_d[p].valid    = gnt_c[p];
      rsp_d[p].is_write = we_i[p];
      rsp_d[p].bank     = BANK_ID_W'(port_bank[p]);
      miss_cnt          = miss_cnt + 32'(req_i[p] && !gnt_c[p]);
    end
    conflict_sum = {1'b0, conflict_q} + {1'b0, miss_cnt};
    conflict_d   = conflict_sum[32] ? '1 : conflict_sum[31:0];
  end

  // Response data: bank read data for reads, zero for writes.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp_data[p] = '0;
      if (!rsp_q[p].is_write) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (rsp_q[p].bank == BANK_ID_W'(b)) rsp_data[p] = bank_rdata[b];
        end
      end
    end
  end

  // Response pipe, rdata hold registers and conflict counter.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_q[p]  <= '0;
        hold_q[p] <= '0;
      end
      conflict_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_q[p] <= rsp_d[p];
        if (rsp_q[p].valid) hold_q[p] <= rsp_data[p];
      end
      conflict_q <= conflict_d;
    end
  end

  // Live bank data during the rvalid cycle, held copy afterwards.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rvalid_o[p] = rsp_q[p].valid;
      rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rsp_q[p].valid ? rsp_data[p] : hold_q[p];
    end
  end

  assign conflict_o = conflict_q;

endmodule
